// File: rtl/clic_nested.sv
//==============================================================================
// Module   : clic_nested
// Purpose  : Core-local interrupt controller with level/edge inputs, level
//            based arbitration, threshold and preemption nesting stack.
//            Optional machine timer on ID 7, enabled by macro CLIC_TIMER_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clic_nested #(
    parameter int          NUM_IRQ    = 32,
    parameter int          NEST_DEPTH = 4,
    parameter logic [19:0] BASE       = 20'h90000
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               wready,
    input  logic [31:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               rready,
    input  logic [31:0]        raddr,
    output logic [31:0]        rdata,
    output logic               rresp,
    input  logic [NUM_IRQ-1:0] ex_irq,
    input  logic               timer_en,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_valid,
    output logic [5:0]         irq_id,
    output logic [7:0]         irq_level,
    output logic [3:0]         nest_depth
);

    // Level: ctl bits above nlbits kept, remaining low bits forced to one.
    function automatic logic [7:0] calc_level(input logic [7:0] ctl, input logic [3:0] nlbits);
        logic [7:0] mask;
        mask = (nlbits >= 4'd8) ? 8'h00 : (8'hFF >> nlbits);
        return ctl | mask;
    endfunction

    // State
    logic [3:0]         nlbits_q, nlbits_d;
    logic [7:0]         thresh_q, thresh_d;
    logic [NUM_IRQ-1:0] ip_q, ip_d, ie_q, ie_d, attr_q, attr_d, ex_prev_q;
    logic [7:0]         ctl_q [NUM_IRQ];
    logic [7:0]         ctl_d [NUM_IRQ];
    logic [7:0]         stack_q [NEST_DEPTH];
    logic [7:0]         stack_d [NEST_DEPTH];
    logic [3:0]         depth_q, depth_d, depth_mid;
    logic [7:0]         active_q, active_d, active_mid;
    logic               irq_valid_q, irq_valid_d;
    logic [5:0]         irq_id_q, irq_id_d;
    logic [7:0]         irq_level_q, irq_level_d;
    logic [31:0]        rdata_q, rd_val;
    logic               rresp_q;

    // Bus decode
    logic        wr_hit, wr_irq, rd_hit, rd_irq;
    logic [11:0] woff, roff;
    logic [7:0]  wr_id, rd_id;
    assign woff   = waddr[11:0];
    assign roff   = raddr[11:0];
    assign wr_hit = wready && (waddr[31:12] == BASE);
    assign rd_hit = raddr[31:12] == BASE;
    assign wr_irq = wr_hit && (woff[11:10] == 2'b01);
    assign rd_irq = rd_hit && (roff[11:10] == 2'b01);
    assign wr_id  = woff[9:2];
    assign rd_id  = roff[9:2];

    logic ack_acc, done_acc;
    assign ack_acc  = irq_ack && irq_valid_q;
    assign done_acc = irq_done && (depth_q != 4'd0);

    logic unused_sigs;

`ifdef CLIC_TIMER_EN
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        mt_wr;

    // Timer next state: byte-wise bus writes, which suppress the increment.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        mt_wr      = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (wr_hit && woff == 12'h008 && wstrb[b]) begin
                mtime_d[8*b +: 8] = wdata[8*b +: 8];
                mt_wr = 1'b1;
            end
            if (wr_hit && woff == 12'h00C && wstrb[b]) begin
                mtime_d[32+8*b +: 8] = wdata[8*b +: 8];
                mt_wr = 1'b1;
            end
            if (wr_hit && woff == 12'h010 && wstrb[b]) mtimecmp_d[8*b +: 8]    = wdata[8*b +: 8];
            if (wr_hit && woff == 12'h014 && wstrb[b]) mtimecmp_d[32+8*b +: 8] = wdata[8*b +: 8];
        end
        if (!mt_wr && timer_en) mtime_d = mtime_q + 64'd1;
    end

    // Timer registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end
    assign unused_sigs = ^{waddr[1:0], raddr[1:0]};
`else
    assign unused_sigs = ^{waddr[1:0], raddr[1:0], timer_en, wdata};
`endif

    // Configuration and per-IRQ register next state, including pending logic.
    always_comb begin
        nlbits_d = nlbits_q;
        thresh_d = thresh_q;
        if (wr_hit && woff == 12'h000 && wstrb[0]) nlbits_d = wdata[3:0];
        if (wr_hit && woff == 12'h004 && wstrb[0]) thresh_d = wdata[7:0];
        ip_d   = ip_q;
        ie_d   = ie_q;
        attr_d = attr_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ctl_d[i] = ctl_q[i];
            if (wr_irq && int'(wr_id) == i) begin
                if (wstrb[3]) ctl_d[i]  = wdata[31:24];
                if (wstrb[2]) attr_d[i] = wdata[16];
                if (wstrb[1]) ie_d[i]   = wdata[8];
            end
            if (!attr_q[i]) begin
                ip_d[i] = ex_irq[i];
            end else begin
                if (ack_acc && irq_id_q == 6'(i)) ip_d[i] = 1'b0;
                if (wr_irq && int'(wr_id) == i && wstrb[0]) ip_d[i] = wdata[0];
                // A fresh edge always wins over a same-cycle clear.
                if (ex_irq[i] && !ex_prev_q[i]) ip_d[i] = 1'b1;
            end
`ifdef CLIC_TIMER_EN
            if (i == 7) ip_d[i] = (mtime_d >= mtimecmp_d);
`endif
        end
    end

    // Arbitration: highest level among enabled pending IRQs, lowest ID on ties.
    logic       found;
    logic [7:0] win_level, lv;
    logic [5:0] win_id;
    always_comb begin
        found     = 1'b0;
        win_level = 8'd0;
        win_id    = 6'd0;
        lv        = 8'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ie_q[i] && ip_q[i]) begin
                lv = calc_level(ctl_q[i], nlbits_q);
                if (!found || lv > win_level) begin
                    found     = 1'b1;
                    win_level = lv;
                    win_id    = 6'(i);
                end
            end
        end
        irq_valid_d = found && (win_level > thresh_q) && (win_level > active_q)
                      && (int'(depth_q) < NEST_DEPTH) && !ack_acc;
        irq_id_d    = irq_valid_d ? win_id    : 6'd0;
        irq_level_d = irq_valid_d ? win_level : 8'd0;
    end

    // Nesting stack: pop for done first, then push for ack.
    always_comb begin
        depth_mid  = depth_q;
        active_mid = active_q;
        if (done_acc) begin
            depth_mid = depth_q - 4'd1;
            for (int k = 0; k < NEST_DEPTH; k++)
                if (int'(depth_q) - 1 == k) active_mid = stack_q[k];
        end
        for (int k = 0; k < NEST_DEPTH; k++) begin
            stack_d[k] = stack_q[k];
            if (ack_acc && int'(depth_mid) == k) stack_d[k] = active_mid;
        end
        active_d = ack_acc ? irq_level_q : active_mid;
        depth_d  = ack_acc ? depth_mid + 4'd1 : depth_mid;
    end

    // Read data mux; anything outside the window or unmapped reads zero.
    always_comb begin
        rd_val = 32'd0;
        if (rd_hit) begin
            case (roff)
                12'h000: rd_val = {28'd0, nlbits_q};
                12'h004: rd_val = {24'd0, thresh_q};
`ifdef CLIC_TIMER_EN
                12'h008: rd_val = mtime_q[31:0];
                12'h00C: rd_val = mtime_q[63:32];
                12'h010: rd_val = mtimecmp_q[31:0];
                12'h014: rd_val = mtimecmp_q[63:32];
`endif
                12'h018: rd_val = {16'd0, active_q, 4'd0, depth_q};
                default: begin
                    for (int i = 0; i < NUM_IRQ; i++)
                        if (rd_irq && int'(rd_id) == i)
                            rd_val = {ctl_q[i], 7'd0, attr_q[i], 7'd0, ie_q[i], 7'd0, ip_q[i]};
                end
            endcase
        end
    end

    // All controller state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            nlbits_q    <= 4'd0;
            thresh_q    <= 8'd0;
            ip_q        <= '0;
            ie_q        <= '0;
            attr_q      <= '0;
            ex_prev_q   <= '0;
            for (int i = 0; i < NUM_IRQ; i++) ctl_q[i] <= 8'd0;
            for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= 8'd0;
            depth_q     <= 4'd0;
            active_q    <= 8'd0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= 6'd0;
            irq_level_q <= 8'd0;
            rdata_q     <= 32'd0;
            rresp_q     <= 1'b0;
        end else begin
            nlbits_q    <= nlbits_d;
            thresh_q    <= thresh_d;
            ip_q        <= ip_d;
            ie_q        <= ie_d;
            attr_q      <= attr_d;
            ex_prev_q   <= ex_irq;
            for (int i = 0; i < NUM_IRQ; i++) ctl_q[i] <= ctl_d[i];
            for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= stack_d[k];
            depth_q     <= depth_d;
            active_q    <= active_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            irq_level_q <= irq_level_d;
            if (rready) rdata_q <= rd_val;
            rresp_q     <= rready;
        end
    end

    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign irq_level  = irq_level_q;
    assign nest_depth = depth_q;

endmodule

`default_nettype wire

// File: tb/tb_clic_nested.sv
//==============================================================================
// Module   : tb_clic_nested
// Purpose  : Directed self-checking bench for clic_nested (NEST_DEPTH=2).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clic_nested;

    localparam int          NUM_IRQ    = 32;
    localparam int          NEST_DEPTH = 2;
    localparam logic [19:0] BASE       = 20'h90000;
    localparam logic [31:0] B          = {BASE, 12'h000};

    logic               clk = 1'b0;
    logic               resetb = 1'b0;
    logic               wready = 1'b0;
    logic [31:0]        waddr = '0;
    logic [31:0]        wdata = '0;
    logic [3:0]         wstrb = '0;
    logic               rready = 1'b0;
    logic [31:0]        raddr = '0;
    logic [31:0]        rdata;
    logic               rresp;
    logic [NUM_IRQ-1:0] ex_irq = '0;
    logic               timer_en = 1'b0;
    logic               irq_ack = 1'b0;
    logic               irq_done = 1'b0;
    logic               irq_valid;
    logic [5:0]         irq_id;
    logic [7:0]         irq_level;
    logic [3:0]         nest_depth;

    int checks = 0;
    int errors = 0;

    clic_nested #(.NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST_DEPTH), .BASE(BASE)) dut (
        .clk(clk), .resetb(resetb),
        .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .rready(rready), .raddr(raddr), .rdata(rdata), .rresp(rresp),
        .ex_irq(ex_irq), .timer_en(timer_en),
        .irq_ack(irq_ack), .irq_done(irq_done),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_level(irq_level),
        .nest_depth(nest_depth)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wready = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wready = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        rready = 1'b1; raddr = a;
        @(negedge clk);
        rready = 1'b0;
        check_eq({tag, "_rresp"}, {63'd0, rresp}, 64'd1);
        check_eq(tag, {32'd0, rdata}, {32'd0, exp});
    endtask

    task automatic pulse_ack();
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); irq_done = 1'b1;
        @(negedge clk); irq_done = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic v, input logic [5:0] id, input logic [7:0] lv);
        check_eq({tag, "_valid"}, {63'd0, irq_valid}, {63'd0, v});
        if (v) begin
            check_eq({tag, "_id"}, {58'd0, irq_id}, {58'd0, id});
            check_eq({tag, "_level"}, {56'd0, irq_level}, {56'd0, lv});
        end
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_valid", {63'd0, irq_valid}, 64'd0);
        check_eq("rst_depth", {60'd0, nest_depth}, 64'd0);
        check_eq("rst_rresp", {63'd0, rresp}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata}, 64'd0);
        tick(2);
        resetb = 1'b1;
        tick(1);

        // Register access, byte strobes, window decode
        wr(B + 32'h004, 32'h0000_AB00, 4'b0010);
        rd_chk("thresh_strb", B + 32'h004, 32'h0);
        wr(32'h1234_5004, 32'h0000_0055, 4'hF);
        rd_chk("thresh_outside", B + 32'h004, 32'h0);
        rd_chk("read_outside", 32'h1234_5000, 32'h0);
        wr(B + 32'h400 + 4*40, 32'hFFFF_FFFF, 4'hF);
        rd_chk("id_oob", B + 32'h400 + 4*40, 32'h0);
`ifdef CLIC_TIMER_EN
`else
        wr(B + 32'h010, 32'h0000_000A, 4'hF);
        rd_chk("no_timer_cmp", B + 32'h010, 32'h0);
`endif

        // Level IRQ 3: ctl=0xC0, nlbits=2 -> level 0xFF
        wr(B + 32'h000, 32'h2, 4'hF);
        wr(B + 32'h40C, 32'hC000_0100, 4'hF);
        ex_irq[3] = 1'b1;
        tick(1);
        chk_irq("lvl3_lat", 1'b0, 6'd0, 8'd0);
        tick(1);
        chk_irq("lvl3", 1'b1, 6'd3, 8'hFF);
        wr(B + 32'h40C, 32'h0, 4'b0001);
        rd_chk("lvl3_swclr_ignored", B + 32'h40C, 32'hC000_0101);
        ex_irq[3] = 1'b0;
        tick(2);
        chk_irq("lvl3_drop", 1'b0, 6'd0, 8'd0);
        wr(B + 32'h40C, 32'h0, 4'b0010);

        // Preemption and overflow: IRQ5 0x7F, IRQ9 0xBF, IRQ12 0xFF
        wr(B + 32'h414, 32'h4000_0100, 4'hF);
        wr(B + 32'h424, 32'h8000_0100, 4'hF);
        wr(B + 32'h430, 32'hC000_0100, 4'hF);
        ex_irq[5] = 1'b1;
        tick(2);
        chk_irq("pre5", 1'b1, 6'd5, 8'h7F);
        pulse_ack();
        chk_irq("pre5_ackd", 1'b0, 6'd0, 8'd0);
        check_eq("pre_depth1", {60'd0, nest_depth}, 64'd1);
        rd_chk("status1", B + 32'h018, 32'h0000_7F01);
        ex_irq[9] = 1'b1;
        tick(2);
        chk_irq("pre9", 1'b1, 6'd9, 8'hBF);
        pulse_ack();
        check_eq("pre_depth2", {60'd0, nest_depth}, 64'd2);
        rd_chk("status2", B + 32'h018, 32'h0000_BF02);
        ex_irq[12] = 1'b1;
        tick(3);
        chk_irq("ovf_blocked", 1'b0, 6'd0, 8'd0);
        pulse_done();
        check_eq("ovf_depth1", {60'd0, nest_depth}, 64'd1);
        tick(1);
        chk_irq("ovf_after_done", 1'b1, 6'd12, 8'hFF);
        ex_irq[5] = 1'b0; ex_irq[9] = 1'b0; ex_irq[12] = 1'b0;
        tick(3);
        chk_irq("lines_low", 1'b0, 6'd0, 8'd0);
        pulse_done();
        check_eq("pre_depth0", {60'd0, nest_depth}, 64'd0);
        rd_chk("status0", B + 32'h018, 32'h0);
        pulse_done();
        pulse_ack();
        check_eq("spurious_depth", {60'd0, nest_depth}, 64'd0);

        // Edge IRQ 2: ctl=0x40 -> level 0x7F
        wr(B + 32'h408, 32'h4001_0100, 4'hF);
        @(negedge clk); ex_irq[2] = 1'b1;
        @(negedge clk); ex_irq[2] = 1'b0;
        tick(1);
        chk_irq("edge2", 1'b1, 6'd2, 8'h7F);
        rd_chk("edge2_ip_held", B + 32'h408, 32'h4001_0101);
        pulse_ack();
        rd_chk("edge2_ack_clr", B + 32'h408, 32'h4001_0100);
        pulse_done();
        @(negedge clk); ex_irq[2] = 1'b1;
        @(negedge clk); ex_irq[2] = 1'b0;
        tick(1);
        chk_irq("edge2_again", 1'b1, 6'd2, 8'h7F);
        @(negedge clk); ex_irq[2] = 1'b1; irq_ack = 1'b1;
        @(negedge clk); ex_irq[2] = 1'b0; irq_ack = 1'b0;
        check_eq("edge2_coinc_depth", {60'd0, nest_depth}, 64'd1);
        rd_chk("edge2_coinc_ip", B + 32'h408, 32'h4001_0101);
        wr(B + 32'h408, 32'h0, 4'b0001);
        rd_chk("edge2_swclr", B + 32'h408, 32'h4001_0100);
        pulse_done();
        check_eq("edge2_depth0", {60'd0, nest_depth}, 64'd0);

        // Ties and threshold: nlbits=3, ctl=0x80 -> level 0x9F
        wr(B + 32'h000, 32'h3, 4'hF);
        wr(B + 32'h410, 32'h8000_0100, 4'hF);
        wr(B + 32'h418, 32'h8000_0100, 4'hF);
        ex_irq[4] = 1'b1; ex_irq[6] = 1'b1;
        tick(2);
        chk_irq("tie", 1'b1, 6'd4, 8'h9F);
        wr(B + 32'h004, 32'h9F, 4'h1);
        tick(1);
        chk_irq("thresh_eq", 1'b0, 6'd0, 8'd0);
        wr(B + 32'h004, 32'h9E, 4'h1);
        tick(1);
        chk_irq("thresh_below", 1'b1, 6'd4, 8'h9F);
        wr(B + 32'h418, 32'hA000_0000, 4'b1000);
        tick(1);
        chk_irq("higher6", 1'b1, 6'd6, 8'hBF);
        pulse_ack();
        check_eq("pre_reset_depth", {60'd0, nest_depth}, 64'd1);

`ifdef CLIC_TIMER_EN
        ex_irq = '0;
        tick(2);
        pulse_done();
        wr(B + 32'h010, 32'd10, 4'hF);
        wr(B + 32'h008, 32'd0, 4'hF);
        tick(1);
        rd_chk("tmr_ip0", B + 32'h41C, 32'h0);
        @(negedge clk); timer_en = 1'b1;
        tick(9); timer_en = 1'b0;
        rd_chk("tmr_9", B + 32'h008, 32'd9);
        rd_chk("tmr_ip_9", B + 32'h41C, 32'h0);
        @(negedge clk); timer_en = 1'b1;
        @(negedge clk); timer_en = 1'b0;
        rd_chk("tmr_10", B + 32'h008, 32'd10);
        rd_chk("tmr_ip_10", B + 32'h41C, 32'h1);
        wr(B + 32'h010, 32'hFFFF_FFFF, 4'hF);
        wr(B + 32'h014, 32'hFFFF_FFFF, 4'hF);
        tick(1);
        rd_chk("tmr_ip_max", B + 32'h41C, 32'h0);
        pulse_ack();
`endif

        // Asynchronous reset mid-nesting
        #2 resetb = 1'b0;
        #1;
        check_eq("arst_depth", {60'd0, nest_depth}, 64'd0);
        check_eq("arst_valid", {63'd0, irq_valid}, 64'd0);
        check_eq("arst_rresp", {63'd0, rresp}, 64'd0);
        ex_irq = '0;
        tick(1);
        resetb = 1'b1;
        rd_chk("arst_thresh", B + 32'h004, 32'h0);
        rd_chk("arst_irq6", B + 32'h418, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time guard
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/clic_nested.md
CLIC_NESTED -- requirements
Module: clic_nested

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt lines (2..64).
REQ-002 SHALL have parameter NEST_DEPTH, default 4, maximum preemption nesting depth (1..8).
REQ-003 SHALL have parameter BASE, default 20'h90000, register window select compared against addr[31:12].
REQ-004 SHALL have ports, one per line:
 clk  in  1  clock, all state rising-edge;
 resetb  in  1  reset, asynchronous, active-low;
 wready  in  1  write strobe, one write per cycle;
 waddr  in  32  write address;
 wdata  in  32  write data;
 wstrb  in  4  byte enables;
 rready  in  1  read strobe;
 raddr  in  32  read address;
 rdata  out  32  read data;
 rresp  out  1  read data valid pulse;
 ex_irq  in  NUM_IRQ  external interrupt lines, synchronous to clk;
 timer_en  in  1  mtime count enable;
 irq_ack  in  1  core accepts the presented interrupt;
 irq_done  in  1  core executed mret, pop one nesting level;
 irq_valid  out  1  interrupt presented;
 irq_id  out  6  presented interrupt ID;
 irq_level  out  8  presented interrupt level;
 nest_depth  out  4  current nesting depth.

Function
REQ-005 SHALL decode only addresses with addr[31:12]==BASE; writes outside are ignored; reads outside return 0.
REQ-006 SHALL map offsets: 0x000 cfg (nlbits[3:0]), 0x004 thresh[7:0], 0x008/0x00C mtime lo/hi, 0x010/0x014 mtimecmp lo/hi, 0x018 status (read-only: {active_level[15:8], depth[3:0]}), 0x400+4*i per-IRQ word {ctl[31:24], attr[16], ie[8], ip[0]}.
REQ-007 SHALL honour wstrb per byte on every register; unmapped offsets and IDs >= NUM_IRQ read 0 and ignore writes.
REQ-008 SHALL return read data one cycle after rready with rresp high for exactly that cycle.
REQ-009 SHALL set ip while ex_irq[i] is high when attr=0 (level mode), ip following the line each cycle; software writes to ip in level mode have no effect.
REQ-010 SHALL set ip on a 0->1 transition of ex_irq[i] when attr=1 (edge mode); ip stays set until a software clear or an ack of that ID.
REQ-011 SHALL give a detected edge priority over a same-cycle software clear or ack clear, leaving ip=1.
REQ-012 SHALL derive level = top min(nlbits,8) bits of ctl with the remaining low bits forced to 1; nlbits=0 gives level 8'hFF.
REQ-013 SHALL select, among IRQs with ie=1 and ip=1, the highest level; ties go to the lowest ID.
REQ-014 SHALL present the winner only if level > thresh, level > active_level and depth < NEST_DEPTH.
REQ-015 SHALL register irq_valid/irq_id/irq_level, with one cycle latency from a pending/enable/config change.
REQ-016 SHALL, on irq_ack with irq_valid=1, push active_level onto the nest stack, set active_level=irq_level, increment depth, and clear ip of irq_id if it is in edge mode.
REQ-017 SHALL deassert irq_valid in the cycle after an ack until re-arbitration against the new active_level.
REQ-018 SHALL ignore irq_ack when irq_valid=0 and ignore irq_done when depth=0.
REQ-019 SHALL, on irq_done, pop the stack into active_level and decrement depth; if ack and done coincide, apply done first, then ack.
REQ-020 SHALL report active_level=0 when depth=0.

Reset
REQ-021 SHALL on resetb low clear all ip, ie, attr, ctl, cfg, thresh, mtime, mtimecmp, stack and depth, and clear irq_valid, irq_id, irq_level, rdata, rresp and nest_depth, immediately and asynchronously.
REQ-022 SHALL discard an in-progress nesting on reset; the first edge detection after reset uses a previous-sample value of 0.

Configuration
REQ-023 SHALL compile the machine timer in when CLIC_TIMER_EN is defined: mtime increments by 1 per cycle while timer_en=1; a bus write to mtime wins over the increment; ip[7] = (mtime >= mtimecmp), unsigned 64-bit, overriding the attr and ex_irq[7] behaviour.
REQ-024 SHALL, without CLIC_TIMER_EN, omit mtime/mtimecmp (offsets 0x008-0x014 read 0, writes ignored) and treat ID 7 as an ordinary external line.

Verification
REQ-025 Level IRQ 3: ie=1, ctl=0xC0, nlbits=2, thresh=0, ex_irq[3]=1 -> irq_valid=1, irq_id=3, irq_level=0xFF one cycle after ip sets.
REQ-026 Preemption: ack IRQ 5 (level 0x7F), then raise IRQ 9 (level 0xBF) -> IRQ 9 presented at depth 1; ack -> depth 2; two irq_done pulses -> depth 0, active_level 0.
REQ-027 Edge IRQ 2 (attr=1): single-cycle pulse on ex_irq[2] -> ip stays 1; ack -> ip=0; pulse coincident with ack -> ip remains 1.
REQ-028 Ties and threshold: IRQs 4 and 6 both at level 0x9F -> id 4; thresh=0x9F -> irq_valid=0.
REQ-029 Overflow: NEST_DEPTH=2, three increasing-level IRQs -> third not presented until irq_done.
REQ-030 CLIC_TIMER_EN: mtimecmp=10, timer_en=1 from mtime=0 -> ip[7]=1 at mtime=10; writing mtimecmp=0xFFFF_FFFF_FFFF_FFFF clears it.
